kernel_buffer_ctrl: RTL and testbench



---
 rtl/kbuf_pkg.sv | 39 +++
 rtl/kbuf_addr_gen.sv | 64 ++++++
 rtl/kernel_buffer_ctrl.sv | 152 +++++++++++++++
 tb/tb_kernel_buffer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbuf_pkg.sv
// kbuf_pkg: definitions shared by the kernel buffer sequencer and the kernel
// buffer unpack logic.
//   - default geometry (log2 bank count, address width, word width)
//   - sequencer state encoding
//   - bit positions of the fields in the packed io bundle
//     {ioSelect, ioWrite, ioBankSelect[depth-1:0], ioInput[W-1:0]}
package kbuf_pkg;

  localparam int KB_DEPTH = 2;
  localparam int KB_A     = 7;
  localparam int KB_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } kbuf_state_e;

  // Field offsets for the default geometry.
  localparam int IO_SEL      = KB_W + KB_DEPTH + 1;
  localparam int IO_WR       = KB_W + KB_DEPTH;
  localparam int IO_BANK_MSB = KB_W + KB_DEPTH - 1;

  // The same offsets for any geometry, so a re-parameterised instance packs
  // the bundle exactly as the unpack side expects.
  function automatic int ioSelPos(input int w, input int d);
    return w + d + 1;
  endfunction

  function automatic int ioWrPos(input int w, input int d);
    return w + d;
  endfunction

  function automatic int ioBankMsbPos(input int w, input int d);
    return w + d - 1;
  endfunction

endpackage

// File: rtl/kbuf_addr_gen.sv
// kbuf_addr_gen: bank/row counter pair for the kernel buffer sequencer.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        return both counters to zero
//   en_i           advance one step
//   row_only_i     step the row counter every enable (bank stays 0)
//   last_row_i     index of the final row of the current phase
//   bank_o, row_o  current bank and row
//   tc_o           current step is the final one (last bank of last row)
module kbuf_addr_gen #(
  parameter int depth = 2,
  parameter int A     = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             row_only_i,
  input  logic [A:0]       last_row_i,
  output logic [depth-1:0] bank_o,
  output logic [A:0]       row_o,
  output logic             tc_o
);

  localparam logic [depth-1:0] BANK_ONE = 1;
  localparam logic [A:0]       ROW_ONE  = 1;

  logic [depth-1:0] bank_q, bank_d;
  logic [A:0]       row_q, row_d;
  logic             bankWrap;

  // In row-only mode every step moves to the next row.
  assign bankWrap = row_only_i | (&bank_q);
  assign tc_o     = bankWrap & (row_q == last_row_i);
  assign bank_o   = bank_q;
  assign row_o    = row_q;

  always_comb begin
    bank_d = bank_q;
    row_d  = row_q;
    if (clear_i) begin
      bank_d = '0;
      row_d  = '0;
    end else if (en_i) begin
      if (bankWrap) begin
        bank_d = '0;
        row_d  = row_q + ROW_ONE;
      end else begin
        bank_d = bank_q + BANK_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= '0;
      row_q  <= '0;
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/kernel_buffer_ctrl.sv
// kernel_buffer_ctrl: sequencer in front of the banked kernel buffer.
// LOAD scatters a valid/ready word stream row-major across the 2^depth banks;
// READ sweeps the rows once so the convolution unit gets one full row per
// cycle. The two phases are mutually exclusive.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   cfg_rows                 rows to load/read, sampled on a start pulse
//   load_start, read_start   phase start pulses (ignored while busy)
//   in_data/in_valid/in_ready  kernel word stream
//   read_stall               hold the current read row
//   op_valid, op_row         row presented by the buffer this cycle
//   load_done, read_done     one-cycle completion pulses
//   busy                     sequencer not idle
//   address                  shared buffer row address
//   ioInputs                 {ioSelect, ioWrite, ioBankSelect, ioInput}
module kernel_buffer_ctrl
  import kbuf_pkg::*;
#(
  parameter int depth = KB_DEPTH,
  parameter int A     = KB_A,
  parameter int W     = KB_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [A:0]         cfg_rows,
  input  logic               load_start,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               read_start,
  input  logic               read_stall,
  output logic               op_valid,
  output logic [A-1:0]       op_row,
  output logic               load_done,
  output logic               read_done,
  output logic               busy,
  output logic [A-1:0]       address,
  output logic [W+depth+1:0] ioInputs
);

  localparam int SEL_POS      = ioSelPos(W, depth);
  localparam int WR_POS       = ioWrPos(W, depth);
  localparam int BANK_MSB_POS = ioBankMsbPos(W, depth);
  localparam logic [A:0] ROW_ONE = 1;

  kbuf_state_e      state_q;
  logic [A:0]       rows_q;
  logic             op_valid_q;
  logic [A-1:0]     op_row_q;
  logic             load_done_q;
  logic             read_done_q;

  logic             handshake;
  logic             cntEn;
  logic [depth-1:0] bankCnt;
  logic [A:0]       rowCnt;
  logic             lastStep;

  assign handshake = (state_q == LOAD) & in_valid;
  assign cntEn     = handshake | ((state_q == READ) & ~read_stall);

  // Counters sit at zero whenever idle, so each phase starts from row 0.
  kbuf_addr_gen #(
    .depth (depth),
    .A     (A)
  ) u_addr_gen (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clear_i    (state_q == IDLE),
    .en_i       (cntEn),
    .row_only_i (state_q == READ),
    .last_row_i (rows_q - ROW_ONE),
    .bank_o     (bankCnt),
    .row_o      (rowCnt),
    .tc_o       (lastStep)
  );

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign op_valid  = op_valid_q;
  assign op_row    = op_row_q;
  assign load_done = load_done_q;
  assign read_done = read_done_q;
  assign address   = ((state_q == LOAD) || (state_q == READ)) ? rowCnt[A-1:0] : '0;

  // The write strobe and payload follow the handshake combinationally so a
  // word lands in the buffer on the same edge it is accepted.
  always_comb begin
    ioInputs = '0;
    if (state_q == LOAD) begin
      ioInputs[SEL_POS] = 1'b1;
      if (handshake) begin
        ioInputs[WR_POS]                = 1'b1;
        ioInputs[BANK_MSB_POS -: depth] = bankCnt;
        ioInputs[W-1:0]                 = in_data;
      end
    end
  end

  // Phase sequencing. op_valid/op_row are registered because the buffer read
  // is one cycle behind the address; DRAIN presents the final row.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      op_valid_q  <= 1'b0;
      op_row_q    <= '0;
      load_done_q <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      read_done_q <= 1'b0;
      op_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            rows_q <= cfg_rows;
            if (cfg_rows == '0) load_done_q <= 1'b1;
            else                state_q     <= LOAD;
          end else if (read_start) begin
            rows_q <= cfg_rows;
            if (cfg_rows == '0) read_done_q <= 1'b1;
            else                state_q     <= READ;
          end
        end
        LOAD: begin
          if (handshake && lastStep) begin
            state_q     <= IDLE;
            load_done_q <= 1'b1;
          end
        end
        READ: begin
          if (!read_stall) begin
            op_valid_q <= 1'b1;
            op_row_q   <= rowCnt[A-1:0];
            if (lastStep) begin
              state_q     <= DRAIN;
              read_done_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_buffer_ctrl.sv
// tb_kernel_buffer_ctrl: randomized scoreboard bench for kernel_buffer_ctrl.
// Drivers push the expected buffer writes / presented rows when a phase is
// started; an independent monitor pops and compares whenever the DUT strobes
// a write or presents a row.
module tb_kernel_buffer_ctrl;

  localparam int DEPTH = 2;
  localparam int D     = 4;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int IOW   = W + DEPTH + 2;
  localparam int P_SEL = W + DEPTH + 1;
  localparam int P_WR  = W + DEPTH;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [A:0]     cfg_rows = '0;
  logic           load_start = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           read_start = 1'b0;
  logic           read_stall = 1'b0;
  logic           op_valid;
  logic [A-1:0]   op_row;
  logic           load_done;
  logic           read_done;
  logic           busy;
  logic [A-1:0]   address;
  logic [IOW-1:0] ioInputs;

  kernel_buffer_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .cfg_rows   (cfg_rows),
    .load_start (load_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .read_start (read_start),
    .read_stall (read_stall),
    .op_valid   (op_valid),
    .op_row     (op_row),
    .load_done  (load_done),
    .read_done  (read_done),
    .busy       (busy),
    .address    (address),
    .ioInputs   (ioInputs)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DEPTH-1:0] bank;
    logic [A-1:0]     addr;
    logic [W-1:0]     data;
  } wr_t;

  typedef struct {
    int row;
    bit last;
  } rd_t;

  wr_t expWr[$];
  rd_t expRd[$];
  int  pendLoadDone = 0;
  int  pendReadDone = 0;
  int  testsRun = 0;
  int  testsFailed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_op_valid"}, op_valid, 0);
    checkOutput({tag, "_op_row"}, op_row, 0);
    checkOutput({tag, "_load_done"}, load_done, 0);
    checkOutput({tag, "_read_done"}, read_done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_address"}, address, 0);
    checkOutput({tag, "_ioInputs"}, ioInputs, 0);
  endtask

  // Pulse the start inputs for one clock; returns at the next falling edge.
  task automatic applyStimulus(input bit ls, input bit rs, input int rows);
    @(negedge CLK);
    cfg_rows   = (A+1)'(rows);
    load_start = ls;
    read_start = rs;
    @(negedge CLK);
    load_start = 1'b0;
    read_start = 1'b0;
  endtask

  // mode: 0 = always valid, 1 = valid every other cycle, 2 = random valid.
  task automatic doLoad(input int rows, input int mode, input bit bothStart,
                        input bit poke, input int abortAfter);
    int total, sent, guard;
    bit hs, lastV;
    wr_t e;
    logic [W-1:0] words[$];
    total = rows * D;
    sent  = 0;
    guard = 0;
    lastV = 1'b0;
    for (int k = 0; k < total; k++) begin
      words.push_back(W'($urandom));
      e.bank = DEPTH'(k % D);
      e.addr = A'(k / D);
      e.data = words[k];
      expWr.push_back(e);
    end
    pendLoadDone++;
    applyStimulus(1'b1, bothStart, rows);
    if (rows == 0) begin
      #1;
      checkOutput("zeroLoadDone", load_done, 1);
      checkOutput("zeroLoadBusy", busy, 0);
      @(negedge CLK);
      #1;
      checkOutput("zeroLoadDoneOnce", load_done, 0);
      return;
    end
    while (sent < total && guard < 4000) begin
      if (sent == abortAfter) begin
        RST      = 1'b1;
        in_valid = 1'b0;
        expWr.delete();
        pendLoadDone--;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checkResetValues("abort");
        RST = 1'b0;
        return;
      end
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~lastV;
        default: in_valid = ($urandom_range(99) < 50);
      endcase
      lastV   = in_valid;
      in_data = words[sent];
      if (poke && sent == 3) begin
        load_start = 1'b1;
        read_start = 1'b1;
        cfg_rows   = (A+1)'(1);
      end else begin
        load_start = 1'b0;
        read_start = 1'b0;
      end
      #1;
      hs = in_valid & in_ready;
      checkOutput("loadBusy", busy, 1);
      checkOutput("loadReady", in_ready, 1);
      checkOutput("loadSelect", ioInputs[P_SEL], 1);
      checkOutput("loadWriteStrobe", ioInputs[P_WR], in_valid);
      @(posedge CLK);
      if (hs) sent++;
      @(negedge CLK);
      guard++;
    end
    checkOutput("loadTimeout", guard < 4000, 1);
    load_start = 1'b0;
    read_start = 1'b0;
    in_valid   = 1'b1;
    in_data    = W'($urandom);
    #1;
    checkOutput("loadDonePulse", load_done, 1);
    checkOutput("readyDropped", in_ready, 0);
    checkOutput("busyAfterLoad", busy, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    #1;
    checkOutput("loadDoneOnce", load_done, 0);
  endtask

  // mode: 0 = no stall, 1 = two stall cycles at row 1, 2 = random stalls.
  task automatic doRead(input int rows, input int mode);
    int issued, stallCnt, guard;
    bit prevIssued;
    rd_t r;
    pendReadDone++;
    for (int k = 0; k < rows; k++) begin
      r.row  = k;
      r.last = (k == rows - 1);
      expRd.push_back(r);
    end
    applyStimulus(1'b0, 1'b1, rows);
    if (rows == 0) begin
      #1;
      checkOutput("zeroReadDone", read_done, 1);
      checkOutput("zeroReadBusy", busy, 0);
      return;
    end
    issued     = 0;
    stallCnt   = 0;
    guard      = 0;
    prevIssued = 1'b0;
    while (issued < rows && guard < 4000) begin
      case (mode)
        1:       read_stall = (issued == 1 && stallCnt < 2);
        2:       read_stall = ($urandom_range(2) == 0);
        default: read_stall = 1'b0;
      endcase
      #1;
      checkOutput("readAddr", address, issued);
      checkOutput("readBusy", busy, 1);
      checkOutput("readOpValid", op_valid, prevIssued);
      checkOutput("readNoSelect", ioInputs[P_SEL], 0);
      checkOutput("readNoWrite", ioInputs[P_WR], 0);
      @(posedge CLK);
      prevIssued = ~read_stall;
      if (!read_stall) issued++;
      else stallCnt++;
      @(negedge CLK);
      guard++;
    end
    checkOutput("readTimeout", guard < 4000, 1);
    read_stall = 1'b0;
    #1;
    checkOutput("drainBusy", busy, 1);
    checkOutput("drainDone", read_done, 1);
    checkOutput("drainOpValid", op_valid, 1);
    @(negedge CLK);
    #1;
    checkOutput("idleAfterRead", busy, 0);
    checkOutput("readDoneOnce", read_done, 0);
  endtask

  // Monitor: compares every strobed write and presented row with the
  // scoreboard, late in the cycle after all drivers have settled.
  initial begin : monitor
    wr_t e;
    rd_t r;
    forever begin
      @(negedge CLK);
      #4;
      if (!RST) begin
        if (ioInputs[P_WR]) begin
          if (expWr.size() == 0) begin
            checkOutput("unexpectedWrite", 1, 0);
          end else begin
            e = expWr.pop_front();
            checkOutput("wrBank", ioInputs[W +: DEPTH], e.bank);
            checkOutput("wrAddr", address, e.addr);
            checkOutput("wrData", ioInputs[W-1:0], e.data);
            checkOutput("wrSelect", ioInputs[P_SEL], 1);
          end
        end
        if (op_valid) begin
          if (expRd.size() == 0) begin
            checkOutput("unexpectedRow", 1, 0);
          end else begin
            r = expRd.pop_front();
            checkOutput("opRow", op_row, r.row);
            checkOutput("readDoneOnLast", read_done, r.last);
          end
        end
        if (load_done) begin
          checkOutput("loadDoneExpected", pendLoadDone > 0, 1);
          checkOutput("loadDoneAllWritten", expWr.size(), 0);
          if (pendLoadDone > 0) pendLoadDone--;
        end
        if (read_done) begin
          checkOutput("readDoneExpected", pendReadDone > 0, 1);
          if (pendReadDone > 0) pendReadDone--;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    repeat (3) @(negedge CLK);
    #1;
    checkResetValues("reset");
    RST = 1'b0;

    // Back-to-back load of two rows, then the same with toggling valid.
    doLoad(2, 0, 1'b0, 1'b0, -1);
    doLoad(2, 1, 1'b0, 1'b0, -1);

    // Reads: plain, and with a two-cycle stall at row 1.
    doRead(3, 0);
    doRead(3, 1);

    // Simultaneous starts plus starts poked mid-load: only the load runs.
    doLoad(2, 0, 1'b1, 1'b1, -1);

    // Reset after five accepted words, then zero-row starts.
    doLoad(3, 0, 1'b0, 1'b0, 5);
    doLoad(0, 0, 1'b0, 1'b0, -1);
    doRead(0, 0);

    // Full address space read with random stalls.
    doRead(128, 2);

    for (int i = 0; i < 6; i++) begin
      doLoad($urandom_range(4, 1), 2, 1'b0, 1'b0, -1);
      doRead($urandom_range(5, 1), 2);
    end

    repeat (3) @(negedge CLK);
    checkOutput("writesOutstanding", expWr.size(), 0);
    checkOutput("rowsOutstanding", expRd.size(), 0);
    checkOutput("loadDoneOutstanding", pendLoadDone, 0);
    checkOutput("readDoneOutstanding", pendReadDone, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
